sfixed_divider: RTL and testbench

SFIXED_DIVIDER -- requirements
Module: sfixed_divider

---
 rtl/alu_pkg.sv | 12 +
 rtl/div_step.sv | 21 ++
 rtl/sfixed_divider.sv | 118 +++++++++++
 tb/tb_sfixed_divider.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and defaults for the signed fixed-point divider.
package alu_pkg;

  localparam int DEFAULT_BUS_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring shift-subtract step on unsigned magnitudes.
module div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] rem_in,
  input  logic         bit_in,
  input  logic [W:0]   divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0] shifted;

  // Partial remainder is always below the divisor, so the restored value fits in W bits.
  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= divisor);
    rem_out = q_bit ? W'(shifted - divisor) : shifted[W-1:0];
  end

endmodule

// File: rtl/sfixed_divider.sv
// Signed integer divider: fixed latency BUS_WIDTH+2 cycles from accept to done (2 on divide-by-zero).
// start is ignored while busy; results hold between done pulses.
module sfixed_divider
  import alu_pkg::*;
#(
  parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BUS_WIDTH-1:0] data_a,
  input  logic [BUS_WIDTH-1:0] data_b,
  output logic                 busy,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] quotient,
  output logic [BUS_WIDTH-1:0] remainder,
  output logic                 div_zero
);

  localparam int W  = BUS_WIDTH;
  localparam int CW = $clog2(BUS_WIDTH + 1);

  state_t        state, state_nx;
  logic [W:0]    dvd;
  logic [W:0]    dvs;
  logic [W-1:0]  rem;
  logic          sign_a, sign_b, dz;
  logic [CW-1:0] cnt;

  logic [W:0]    a_ext, b_ext, abs_a, abs_b;
  logic [W-1:0]  rem_nx;
  logic          q_bit;
  logic [W-1:0]  q_mag;

  // Widened by one bit so the magnitude of the most-negative value is exact.
  always_comb begin
    a_ext = {data_a[W-1], data_a};
    b_ext = {data_b[W-1], data_b};
    abs_a = data_a[W-1] ? -a_ext : a_ext;
    abs_b = data_b[W-1] ? -b_ext : b_ext;
    q_mag = dvd[W-1:0];
  end

  div_step #(.W(W)) u_step (
    .rem_in  (rem),
    .bit_in  (dvd[W-1]),
    .divisor (dvs),
    .rem_out (rem_nx),
    .q_bit   (q_bit)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (data_b == '0) ? SIGN : CALC;
      CALC:    if (cnt == CW'(W - 1)) state_nx = SIGN;
      SIGN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      dz        <= 1'b0;
      cnt       <= '0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd    <= abs_a;
            dvs    <= abs_b;
            rem    <= '0;
            sign_a <= data_a[W-1];
            sign_b <= data_b[W-1];
            dz     <= (data_b == '0);
            cnt    <= '0;
          end
        end
        CALC: begin
          // Quotient bits shift in at the bottom as dividend bits leave the top.
          rem <= rem_nx;
          dvd <= {dvd[W-1:0], q_bit};
          cnt <= cnt + 1'b1;
        end
        SIGN: begin
          done     <= 1'b1;
          div_zero <= dz;
          if (dz) begin
            quotient  <= '1;
            remainder <= sign_a ? W'(-dvd) : dvd[W-1:0];
          end else begin
            quotient  <= (sign_a ^ sign_b) ? -q_mag : q_mag;
            remainder <= sign_a ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sfixed_divider.sv
// Scoreboard bench for sfixed_divider: directed vectors with hand-computed results.
module tb_sfixed_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] data_a = '0;
  logic [W-1:0] data_b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] quotient, remainder;

  sfixed_divider #(.BUS_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_a    (data_a),
    .data_b    (data_b),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           acc;
    int           lat;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d with no request outstanding", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_quotient"}, 32'(quotient), 32'(e.q));
        chk({e.tag, "_remainder"}, 32'(remainder), 32'(e.r));
        chk({e.tag, "_div_zero"}, 32'(div_zero), 32'(e.dz));
        chk({e.tag, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  // Called #1 after a rising edge; the current cycle is the accepting cycle.
  task automatic issue(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic push, input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edz, input int lat);
    exp_t e;
    data_a = a;
    data_b = b;
    start  = 1'b1;
    if (push) begin
      e.q = eq; e.r = er; e.dz = edz; e.acc = cyc; e.lat = lat; e.tag = tag;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start  = 1'b0;
    data_a = ~a;
    data_b = b + 8'd3;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d results still pending, required 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int a0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_quotient", 32'(quotient), 0);
    chk("reset_remainder", 32'(remainder), 0);
    chk("reset_div_zero", 32'(div_zero), 0);

    issue("d100_7", 8'd100, 8'd7, 1'b1, 8'd14, 8'd2, 1'b0, 10);
    chk("busy_after_accept", 32'(busy), 1);
    wait_drain("d100_7");

    issue("dm100_7", 8'h9C, 8'd7, 1'b1, 8'hF2, 8'hFE, 1'b0, 10);
    wait_drain("dm100_7");
    issue("d100_m7", 8'd100, 8'hF9, 1'b1, 8'hF2, 8'h02, 1'b0, 10);
    wait_drain("d100_m7");
    issue("d7_0", 8'd7, 8'd0, 1'b1, 8'hFF, 8'h07, 1'b1, 2);
    wait_drain("d7_0");
    issue("dm5_0", 8'hFB, 8'd0, 1'b1, 8'hFF, 8'hFB, 1'b1, 2);
    wait_drain("dm5_0");
    issue("dm128_m1", 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 10);
    wait_drain("dm128_m1");
    issue("dm128_7", 8'h80, 8'd7, 1'b1, 8'hEE, 8'hFE, 1'b0, 10);
    wait_drain("dm128_7");
    issue("d5_9", 8'd5, 8'd9, 1'b1, 8'd0, 8'd5, 1'b0, 10);
    wait_drain("d5_9");
    issue("d127_m128", 8'd127, 8'h80, 1'b1, 8'd0, 8'd127, 1'b0, 10);
    wait_drain("d127_m128");

    // Busy start ignored; start on the done cycle accepted back-to-back.
    a0 = cyc;
    issue("d50_5", 8'd50, 8'd5, 1'b1, 8'd10, 8'd0, 1'b0, 10);
    wait_until(a0 + 4);
    issue("busy_ign", 8'd9, 8'd3, 1'b0, 8'd0, 8'd0, 1'b0, 0);
    wait_until(a0 + 10);
    chk("done_cycle_done", 32'(done), 1);
    issue("d9_3_b2b", 8'd9, 8'd3, 1'b1, 8'd3, 8'd0, 1'b0, 10);
    @(posedge clk); #1;
    chk("hold_busy_quotient", 32'(quotient), 10);
    chk("hold_busy_remainder", 32'(remainder), 0);
    wait_drain("d9_3_b2b");

    // Reset mid-division aborts without done.
    a0 = cyc;
    issue("abort", 8'd100, 8'd7, 1'b0, 8'd0, 8'd0, 1'b0, 0);
    wait_until(a0 + 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_quotient", 32'(quotient), 0);
    chk("abort_remainder", 32'(remainder), 0);
    chk("abort_div_zero", 32'(div_zero), 0);
    repeat (15) @(posedge clk);
    #1;
    issue("post_rst", 8'd100, 8'd7, 1'b1, 8'd14, 8'd2, 1'b0, 10);
    wait_drain("post_rst");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
